// File: rtl/alu_pkg.sv
// Shared opcode constants and FSM state type for the ALU control / execute path.
// Used by multicycle_alu and by the upstream ALU control stage.
package alu_pkg;

    localparam logic [3:0] OP_AND     = 4'b0000;
    localparam logic [3:0] OP_OR      = 4'b0001;
    localparam logic [3:0] OP_NOR     = 4'b0010;
    localparam logic [3:0] OP_ADD     = 4'b0011;
    localparam logic [3:0] OP_SUB     = 4'b0100;
    localparam logic [3:0] OP_LUI     = 4'b0101;
    localparam logic [3:0] OP_SLL     = 4'b0110;
    localparam logic [3:0] OP_SRL     = 4'b0111;
    localparam logic [3:0] OP_ILLEGAL = 4'b1001;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } alu_state_t;

    function automatic logic is_shift_op(input logic [3:0] op);
        return (op == OP_SLL) || (op == OP_SRL);
    endfunction

endpackage

// File: rtl/alu_serial_shifter.sv
// One-bit-per-cycle shifter with a down-counting step count.
// last flags the step whose shifted value is the final result.
module alu_serial_shifter #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic                  dir_right,
    input  logic [4:0]            count_in,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  step,
    output logic [DATA_WIDTH-1:0] shifted,
    output logic                  last
);

    logic [DATA_WIDTH-1:0] sreg;
    logic [4:0]            count;
    logic                  dir;

    assign shifted = dir ? (sreg >> 1) : (sreg << 1);
    assign last    = (count == 5'd1);

    always_ff @(posedge clk) begin
        if (!reset) begin
            sreg  <= '0;
            count <= '0;
            dir   <= 1'b0;
        end else if (load) begin
            sreg  <= data_in;
            count <= count_in;
            dir   <= dir_right;
        end else if (step && (count != 5'd0)) begin
            sreg  <= shifted;
            count <= count - 5'd1;
        end
    end

endmodule

// File: rtl/multicycle_alu.sv
// Execute-stage ALU: single-cycle logic/arith/LUI, serial SLL/SRL.
// Optional Overflow output enabled by defining ALU_OVERFLOW_EN.
//
// state    | meaning
// ST_IDLE  | waiting for start; single-cycle ops complete from here
// ST_SHIFT | serial shift in progress, busy high
module multicycle_alu
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [3:0]            ALUOperation,
    input  logic [DATA_WIDTH-1:0] A,
    input  logic [DATA_WIDTH-1:0] B,
    input  logic [4:0]            shamt,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] ALUResult,
    output logic                  Zero,
    output logic                  Illegal
`ifdef ALU_OVERFLOW_EN
    ,
    output logic                  Overflow
`endif
);

    localparam int MSB = DATA_WIDTH - 1;

    alu_state_t            state_q, state_d;
    logic [DATA_WIDTH-1:0] sum, diff, op_result, res_d, shifted;
    logic                  op_illegal, ill_d, upd;
    logic                  shf_load, shf_step, last;

    assign sum  = A + B;
    assign diff = A - B;
    assign busy = (state_q == ST_SHIFT);

    always_comb begin
        op_result  = '0;
        op_illegal = 1'b0;
        case (ALUOperation)
            OP_AND: op_result = A & B;
            OP_OR:  op_result = A | B;
            OP_NOR: op_result = ~(A | B);
            OP_ADD: op_result = sum;
            OP_SUB: op_result = diff;
            OP_LUI: op_result = {B[15:0], {(DATA_WIDTH-16){1'b0}}};
            // shamt 0/1 finish here; longer shifts go through the serial shifter
            OP_SLL: op_result = (shamt == 5'd0) ? B : (B << 1);
            OP_SRL: op_result = (shamt == 5'd0) ? B : (B >> 1);
            default: begin
                op_result  = '0;
                op_illegal = 1'b1;
            end
        endcase
    end

    always_comb begin
        state_d  = state_q;
        shf_load = 1'b0;
        shf_step = 1'b0;
        upd      = 1'b0;
        res_d    = op_result;
        ill_d    = op_illegal;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (is_shift_op(ALUOperation) && (shamt > 5'd1)) begin
                        shf_load = 1'b1;
                        state_d  = ST_SHIFT;
                    end else begin
                        upd = 1'b1;
                    end
                end
            end
            ST_SHIFT: begin
                shf_step = 1'b1;
                if (last) begin
                    upd     = 1'b1;
                    res_d   = shifted;
                    ill_d   = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // The first bit is shifted at load so an n-bit shift completes in n cycles.
    alu_serial_shifter #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_shifter (
        .clk      (clk),
        .reset    (reset),
        .load     (shf_load),
        .dir_right(ALUOperation == OP_SRL),
        .count_in (shamt - 5'd1),
        .data_in  ((ALUOperation == OP_SRL) ? (B >> 1) : (B << 1)),
        .step     (shf_step),
        .shifted  (shifted),
        .last     (last)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            done      <= 1'b0;
            ALUResult <= '0;
            Zero      <= 1'b1;
            Illegal   <= 1'b0;
        end else begin
            state_q <= state_d;
            done    <= upd;
            if (upd) begin
                ALUResult <= res_d;
                Zero      <= (res_d == '0);
                Illegal   <= ill_d;
            end
        end
    end

`ifdef ALU_OVERFLOW_EN
    logic op_ovf;

    always_comb begin
        op_ovf = 1'b0;
        if (ALUOperation == OP_ADD)
            op_ovf = (A[MSB] == B[MSB]) && (sum[MSB] != A[MSB]);
        else if (ALUOperation == OP_SUB)
            op_ovf = (A[MSB] != B[MSB]) && (diff[MSB] != A[MSB]);
    end

    always_ff @(posedge clk) begin
        if (!reset)
            Overflow <= 1'b0;
        else if (upd)
            Overflow <= (state_q == ST_IDLE) ? op_ovf : 1'b0;
    end
`endif

endmodule
